icache_axi_rd_responder: RTL and testbench
==========================================

// Module: icache_axi_rd_responder
// PURPOSE
//  Serves ICache refill reads: accepts valid/addr/len from the ICache miss port, issues one
//  AXI4 INCR read burst, and returns each beat with ready/data plus last on the final beat.
//  Sits between the ICache and the SoC AXI crossbar master port. Read-only; AW/W/B are not driven.
// PARAMETERS
//  ADDR_W   32  AXI/cache address width
//  DATA_W   32  beat width; arsize = log2(DATA_W/8)
//  LEN_W    8   burst length field width (beats = len+1)
//  AXI_ID   0   constant arid
// PORTS
//  clock             in   1       rising-edge clock
//  reset             in   1       asynchronous, active-low reset
//  cache_r_valid_i   in   1       refill request; held with addr/len until last beat returned
//  cache_r_addr_i    in   ADDR_W  burst start address (DATA_W-aligned)
//  cache_r_len_i     in   LEN_W   beats-1
//  cache_r_ready_o   out  1       one-cycle pulse per returned beat; data valid this cycle
//  cache_r_data_o    out  DATA_W  beat data
//  cache_r_last_o    out  1       final beat of burst, coincident with cache_r_ready_o
//  cache_r_err_o     out  1       with last: any beat had rresp!=OKAY or burst length mismatch
//  arvalid_o/arready_i  out/in 1  AXI AR handshake
//  araddr_o          out  ADDR_W  = latched addr
//  arlen_o           out  LEN_W   = latched len
//  arsize_o          out  3       log2(DATA_W/8)
//  arburst_o         out  2       2'b01 (INCR)
//  arid_o            out  4       AXI_ID
//  rvalid_i/rready_o in/out 1     AXI R handshake
//  rdata_i           in   DATA_W  read data
//  rresp_i           in   2       read response
//  rlast_i           in   1       AXI last beat
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; every output 0 except arsize/arburst/arid constants;
//   beat counter, err flag, latched addr/len cleared. Reset mid-burst abandons the burst.
//  FSM: IDLE -> AR -> R -> IDLE.
//   IDLE: cache_r_valid_i=1 -> latch addr/len, clear cnt/err, go AR (arvalid_o=1 next cycle).
//   AR: arvalid_o=1, addr/len stable; arready_i=1 -> arvalid_o=0, go R. Never retracts arvalid.
//   R: rready_o=1 combinationally. Each rvalid&rready: cnt++; err |= (rresp!=0);
//    beat registered to cache port next cycle: cache_r_ready_o=1, data=rdata.
//    Final beat = rlast_i OR cnt==len. err |= (rlast_i != (cnt==len)) (early/missing rlast).
//    On final beat: cache_r_last_o=1, cache_r_err_o=err (incl. this beat), go IDLE.
//    If rlast missing at cnt==len, remaining AXI beats are accepted in IDLE (rready_o=1)
//    and dropped until rlast_i; new requests wait until drained.
//  Latency: request seen cycle 0 -> arvalid cycle 1; R handshake cycle k -> cache_r_ready_o k+1.
//  Throughput: one beat/cycle; no backpressure toward AXI (cache accepts every pulse).
//  Cache-side abort: if cache_r_valid_i drops after IDLE, AXI burst still completes; cache
//   outputs suppressed (ready/last stay 0) for remaining beats; back to IDLE after final beat.
//  cnt is LEN_W bits; len=255 gives 256 beats without wrap error. Requests in AR/R ignored.
//  cache_r_ready_o/last/err are single-cycle pulses; data holds last value otherwise.
// TESTING
//  1. len=0, addr=0x3000_0010, arready same cycle, rdata=0xDEADBEEF rlast=1 -> arlen=0, one
//     ready pulse data=0xDEADBEEF, last=1, err=0, IDLE 1 cycle later.
//  2. len=3, arready delayed 5 cycles -> arvalid held 5 cycles with araddr stable; 4 pulses,
//     last only on 4th, data order preserved.
//  3. len=3, rvalid gaps (1,0,0,1,1,0,1) -> exactly 4 pulses each 1 cycle after accepted beat.
//  4. beat 2 of 4 rresp=2'b10 -> all 4 beats delivered, err=1 with last.
//  5. len=3, rlast on beat 2 -> last+err=1 on beat 2; rlast missing -> last+err at beat 4,
//     extra AXI beats drained, next request's arvalid only after rlast.
//  6. reset low mid-burst (beat 2) -> all outputs 0 same cycle, IDLE; new request after
//     release issues fresh AR with new addr.

Source files
------------

// File: rtl/icache_axi_rd_responder_if.sv
// ---------------------------------------------------------------------------
// icache_axi_rd_responder_if
// AXI4 read-address and read-data channel bundle between the ICache refill
// responder and the SoC crossbar.
//   master modport : the responder (drives AR, accepts R)
//   slave  modport : the memory / crossbar side (accepts AR, drives R)
// Signals:
//   arvalid/arready  AR handshake
//   araddr/arlen     burst start address and beats-1
//   arsize/arburst   beat size (log2 bytes) and burst type
//   arid             transaction id
//   rvalid/rready    R handshake
//   rdata/rresp      beat data and response code
//   rlast            final beat of the burst
// ---------------------------------------------------------------------------
interface icache_axi_rd_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [3:0]        arid;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/icache_axi_rd_responder.sv
// ---------------------------------------------------------------------------
// icache_axi_rd_responder
// Turns one ICache refill request into a single AXI4 INCR read burst and
// streams the returned beats back to the cache, one pulse per beat.
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   cache_r_valid_i/addr_i/len_i refill request, held until the last beat
//   cache_r_ready_o/data_o       one-cycle pulse per beat with its data
//   cache_r_last_o/err_o         final-beat marker and burst error status
//   axi                          AXI AR/R channels (master modport)
// ---------------------------------------------------------------------------
module icache_axi_rd_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int AXI_ID = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cache_r_valid_i,
    input  logic [ADDR_W-1:0]         cache_r_addr_i,
    input  logic [LEN_W-1:0]          cache_r_len_i,
    output logic                      cache_r_ready_o,
    output logic [DATA_W-1:0]         cache_r_data_o,
    output logic                      cache_r_last_o,
    output logic                      cache_r_err_o,
    icache_axi_rd_responder_if.master axi
);

    localparam logic [2:0] ARSIZE = 3'($clog2(DATA_W / 8));
    localparam logic [3:0] ARID   = 4'(AXI_ID);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [LEN_W-1:0]  len_r, len_s;
    logic [LEN_W-1:0]  cnt_r, cnt_s;
    logic              err_r, err_s;
    logic              drain_r, drain_s;     // dropping surplus beats until rlast
    logic              abort_r, abort_s;     // cache gave up; beats not forwarded
    logic              arvalid_r, arvalid_s;
    logic              rready_r, rready_s;
    logic              ready_r, ready_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic              last_r, last_s;
    logic              cerr_r, cerr_s;

    logic beat_s;
    logic at_len_s;
    logic final_s;
    logic beat_err_s;
    logic quiet_s;

    assign beat_s     = axi.rvalid & rready_r;
    assign at_len_s   = (cnt_r == len_r);
    // A burst ends at rlast or at the requested length, whichever comes
    // first; any disagreement between the two is a protocol error.
    assign final_s    = axi.rlast | at_len_s;
    assign beat_err_s = err_r | (axi.rresp != 2'b00) | (axi.rlast != at_len_s);
    assign quiet_s    = abort_r | ~cache_r_valid_i;

    // Next-state and next-output logic for the IDLE/AR/R sequencer
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        len_s     = len_r;
        cnt_s     = cnt_r;
        err_s     = err_r;
        drain_s   = drain_r;
        abort_s   = abort_r;
        arvalid_s = arvalid_r;
        rready_s  = rready_r;
        ready_s   = 1'b0;
        data_s    = data_r;
        last_s    = 1'b0;
        cerr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (drain_r) begin
                    if (beat_s && axi.rlast) begin
                        drain_s  = 1'b0;
                        rready_s = 1'b0;
                    end else begin
                        drain_s  = 1'b1;
                    end
                // The cache may still hold valid while the last pulse is out;
                // that cycle must not be mistaken for a new request.
                end else if (cache_r_valid_i && !last_r) begin
                    addr_s    = cache_r_addr_i;
                    len_s     = cache_r_len_i;
                    cnt_s     = {LEN_W{1'b0}};
                    err_s     = 1'b0;
                    abort_s   = 1'b0;
                    arvalid_s = 1'b1;
                    state_s   = ST_AR;
                end else begin
                    arvalid_s = 1'b0;
                end
            end
            ST_AR: begin
                abort_s = quiet_s;
                if (axi.arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = ST_R;
                end else begin
                    arvalid_s = 1'b1;
                end
            end
            ST_R: begin
                abort_s = quiet_s;
                if (beat_s) begin
                    cnt_s = cnt_r + LEN_W'(1);
                    err_s = beat_err_s;
                    if (!quiet_s) begin
                        ready_s = 1'b1;
                        data_s  = axi.rdata;
                    end else begin
                        ready_s = 1'b0;
                    end
                    if (final_s) begin
                        last_s   = ~quiet_s;
                        cerr_s   = ~quiet_s & beat_err_s;
                        drain_s  = ~axi.rlast;
                        rready_s = ~axi.rlast;
                        state_s  = ST_IDLE;
                    end else begin
                        state_s  = ST_R;
                    end
                end else begin
                    state_s = ST_R;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
                drain_s   = 1'b0;
            end
        endcase
    end

    // State, latched request and registered output flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            addr_r    <= '0;
            len_r     <= '0;
            cnt_r     <= '0;
            err_r     <= 1'b0;
            drain_r   <= 1'b0;
            abort_r   <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            ready_r   <= 1'b0;
            data_r    <= '0;
            last_r    <= 1'b0;
            cerr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            len_r     <= len_s;
            cnt_r     <= cnt_s;
            err_r     <= err_s;
            drain_r   <= drain_s;
            abort_r   <= abort_s;
            arvalid_r <= arvalid_s;
            rready_r  <= rready_s;
            ready_r   <= ready_s;
            data_r    <= data_s;
            last_r    <= last_s;
            cerr_r    <= cerr_s;
        end
    end

    assign cache_r_ready_o = ready_r;
    assign cache_r_data_o  = data_r;
    assign cache_r_last_o  = last_r;
    assign cache_r_err_o   = cerr_r;

    assign axi.arvalid = arvalid_r;
    assign axi.araddr  = addr_r;
    assign axi.arlen   = len_r;
    assign axi.arsize  = ARSIZE;
    assign axi.arburst = 2'b01;
    assign axi.arid    = ARID;
    assign axi.rready  = rready_r;

endmodule

// File: tb/tb_icache_axi_rd_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_axi_rd_responder
// Drives refill requests and an AXI read slave, and compares the cache-side
// beat pulses with a reference built from the burst description.
// ---------------------------------------------------------------------------
module tb_icache_axi_rd_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cache_r_valid_i;
    logic [31:0] cache_r_addr_i;
    logic [7:0]  cache_r_len_i;
    logic        cache_r_ready_o;
    logic [31:0] cache_r_data_o;
    logic        cache_r_last_o;
    logic        cache_r_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    icache_axi_rd_responder_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) axi ();

    icache_axi_rd_responder #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .AXI_ID(0)) dut (
        .clock           (clock),
        .reset           (reset),
        .cache_r_valid_i (cache_r_valid_i),
        .cache_r_addr_i  (cache_r_addr_i),
        .cache_r_len_i   (cache_r_len_i),
        .cache_r_ready_o (cache_r_ready_o),
        .cache_r_data_o  (cache_r_data_o),
        .cache_r_last_o  (cache_r_last_o),
        .cache_r_err_o   (cache_r_err_o),
        .axi             (axi)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // burst description driven by the AXI slave
    logic [31:0] b_data[$];
    logic [1:0]  b_resp[$];
    bit          b_last[$];
    int          b_gap[$];
    int          cfg_ar_delay;
    int          cfg_drop_after;
    bit          cfg_next_req;
    logic [31:0] cfg_next_addr;
    logic [7:0]  cfg_next_len;

    // observations
    logic [31:0] o_data[$];
    bit          o_last[$];
    bit          o_err[$];
    int          o_cyc[$];
    int          hs_cyc[$];
    int          ar_seen, first_ar_cyc, second_ar_cyc, req_cyc, drop_cyc;
    bit          ar_addr_bad, timed_out;

    // expectations
    logic [31:0] e_data[$];
    bit          e_last[$];
    bit          e_err[$];

    task automatic clear_cfg();
        b_data.delete(); b_resp.delete(); b_last.delete(); b_gap.delete();
        cfg_ar_delay = 0; cfg_drop_after = -1; cfg_next_req = 1'b0;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [1:0] r, input bit l, input int g);
        b_data.push_back(d); b_resp.push_back(r); b_last.push_back(l); b_gap.push_back(g);
    endtask

    // Reference: the cache sees every beat up to the first one that is either
    // flagged rlast or is beat number len; err reports bad responses up to it
    // and whether rlast sat anywhere other than beat len.
    task automatic build_expect(input logic [7:0] len);
        int  f;
        bit  bad;
        e_data.delete(); e_last.delete(); e_err.delete();
        f = -1;
        for (int i = 0; i < b_data.size(); i++) begin
            if (b_last[i] || i == int'(len)) begin f = i; break; end
        end
        bad = 1'b0;
        for (int i = 0; i <= f; i++) if (b_resp[i] != 2'b00) bad = 1'b1;
        if (f >= 0 && (b_last[f] != (f == int'(len)))) bad = 1'b1;
        for (int i = 0; i <= f; i++) begin
            e_data.push_back(b_data[i]);
            e_last.push_back(i == f);
            e_err.push_back((i == f) && bad);
        end
    endtask

    // Issues one request, plays the AXI slave and records cache pulses.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len);
        int phase, bi, gap, settle, guard;
        o_data.delete(); o_last.delete(); o_err.delete(); o_cyc.delete(); hs_cyc.delete();
        ar_seen = 0; first_ar_cyc = -1; second_ar_cyc = -1; drop_cyc = 1 << 30;
        ar_addr_bad = 1'b0; timed_out = 1'b0;
        phase = 0; bi = 0; settle = 0; guard = 0;
        gap = (b_gap.size() > 0) ? b_gap[0] : 0;
        @(negedge clock);
        cache_r_valid_i = 1'b1; cache_r_addr_i = addr; cache_r_len_i = len;
        req_cyc = cyc + 1;
        while (1) begin
            @(negedge clock);
            guard++;
            if (guard > 3000) begin timed_out = 1'b1; break; end
            if (cache_r_ready_o) begin
                o_data.push_back(cache_r_data_o); o_last.push_back(cache_r_last_o);
                o_err.push_back(cache_r_err_o); o_cyc.push_back(cyc);
                if (cache_r_last_o) begin
                    if (cfg_next_req) begin
                        cache_r_addr_i = cfg_next_addr; cache_r_len_i = cfg_next_len;
                    end else begin
                        cache_r_valid_i = 1'b0;
                    end
                end
            end
            if (cfg_drop_after >= 0 && o_data.size() == cfg_drop_after && cache_r_valid_i
                && drop_cyc == (1 << 30)) begin
                cache_r_valid_i = 1'b0; drop_cyc = cyc + 1;
            end
            axi.rvalid = 1'b0;
            if (phase == 1) begin
                if (gap > 0) gap--;
                else begin
                    axi.rvalid = 1'b1; axi.rdata = b_data[bi];
                    axi.rresp = b_resp[bi]; axi.rlast = b_last[bi];
                    if (axi.rready) begin
                        hs_cyc.push_back(cyc + 1);
                        bi++;
                        if (bi == b_data.size()) phase = 2; else gap = b_gap[bi];
                    end
                end
            end
            axi.arready = 1'b0;
            if (phase == 0) begin
                if (axi.arvalid) begin
                    if (first_ar_cyc < 0) first_ar_cyc = cyc;
                    if (axi.araddr !== addr || axi.arlen !== len) ar_addr_bad = 1'b1;
                    ar_seen++;
                    if (ar_seen > cfg_ar_delay) begin axi.arready = 1'b1; phase = 1; end
                end
            end else if (phase == 2) begin
                if (axi.arvalid && second_ar_cyc < 0) second_ar_cyc = cyc;
                settle++;
                if (settle > 4) break;
            end
        end
        axi.rvalid = 1'b0; axi.arready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({cache_r_ready_o, cache_r_last_o, cache_r_err_o, axi.arvalid, axi.rready} !== 5'b0
            || cache_r_data_o !== 32'h0 || axi.araddr !== 32'h0 || axi.arlen !== 8'h0
            || axi.arsize !== 3'd2 || axi.arburst !== 2'b01 || axi.arid !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b last=%b err=%b arv=%b rrdy=%b data=%h araddr=%h arlen=%h arsize=%0d arburst=%b arid=%0d, want zeros with arsize=2 arburst=01 arid=0",
                     cache_r_ready_o, cache_r_last_o, cache_r_err_o, axi.arvalid, axi.rready,
                     cache_r_data_o, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single();
        clear_cfg();
        push_beat(32'hDEADBEEF, 2'b00, 1'b1, 0);
        build_expect(8'd0);
        run_burst(32'h3000_0010, 8'd0);
        n_checks++;
        if (ar_addr_bad || ar_seen != 1 || first_ar_cyc != req_cyc) begin
            n_fail++;
            $display("FAIL single_ar: bad_addr=%b ar_cycles=%0d first_ar=%0d, want bad_addr=0 ar_cycles=1 first_ar=%0d",
                     ar_addr_bad, ar_seen, first_ar_cyc, req_cyc);
        end
        n_checks++;
        if (timed_out || o_data.size() != e_data.size() || hs_cyc.size() != b_data.size()) begin
            n_fail++;
            $display("FAIL single_count: pulses=%0d beats=%0d timeout=%b, want pulses=%0d beats=%0d",
                     o_data.size(), hs_cyc.size(), timed_out, e_data.size(), b_data.size());
        end
        for (int i = 0; i < o_data.size() && i < e_data.size() && i < hs_cyc.size(); i++) begin
            n_checks++;
            if (o_data[i] !== e_data[i] || o_last[i] !== e_last[i] || o_err[i] !== e_err[i] || o_cyc[i] != hs_cyc[i]) begin
                n_fail++;
                $display("FAIL single_beat%0d: data=%h last=%b err=%b cyc=%0d, want data=%h last=%b err=%b cyc=%0d",
                         i, o_data[i], o_last[i], o_err[i], o_cyc[i], e_data[i], e_last[i], e_err[i], hs_cyc[i]);
            end
        end
        n_checks++;
        if (axi.rready !== 1'b0 || axi.arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: rready=%b arvalid=%b, want 0 0", axi.rready, axi.arvalid);
        end
    endtask

    task automatic test_ar_delay();
        clear_cfg();
        cfg_ar_delay = 5;
        for (int i = 0; i < 4; i++) push_beat(32'hA000_0000 + 32'(i), 2'b00, i == 3, 0);
        build_expect(8'd3);
        run_burst(32'h1234_5670, 8'd3);
        n_checks++;
        if (ar_addr_bad || ar_seen != 6) begin
            n_fail++;
            $display("FAIL ar_delay_hold: bad_addr=%b ar_cycles=%0d, want bad_addr=0 ar_cycles=6", ar_addr_bad, ar_seen);
        end
        n_checks++;
        if (timed_out || o_data.size() != e_data.size()) begin
            n_fail++;
            $display("FAIL ar_delay_count: pulses=%0d timeout=%b, want pulses=%0d", o_data.size(), timed_out, e_data.size());
        end
        for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
            n_checks++;
            if (o_data[i] !== e_data[i] || o_last[i] !== e_last[i] || o_err[i] !== e_err[i]) begin
                n_fail++;
                $display("FAIL ar_delay_beat%0d: data=%h last=%b err=%b, want data=%h last=%b err=%b",
                         i, o_data[i], o_last[i], o_err[i], e_data[i], e_last[i], e_err[i]);
            end
        end
    endtask

    task automatic test_rvalid_gaps();
        int gaps[4] = '{0, 2, 0, 1};
        clear_cfg();
        for (int i = 0; i < 4; i++) push_beat(32'hB0B0_0000 + 32'(i * 16), 2'b00, i == 3, gaps[i]);
        build_expect(8'd3);
        run_burst(32'h0000_8000, 8'd3);
        n_checks++;
        if (timed_out || o_data.size() != 4 || hs_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL gaps_count: pulses=%0d beats=%0d timeout=%b, want 4 4", o_data.size(), hs_cyc.size(), timed_out);
        end
        for (int i = 0; i < o_data.size() && i < e_data.size() && i < hs_cyc.size(); i++) begin
            n_checks++;
            if (o_data[i] !== e_data[i] || o_last[i] !== e_last[i] || o_err[i] !== e_err[i] || o_cyc[i] != hs_cyc[i]) begin
                n_fail++;
                $display("FAIL gaps_beat%0d: data=%h last=%b err=%b cyc=%0d, want data=%h last=%b err=%b cyc=%0d",
                         i, o_data[i], o_last[i], o_err[i], o_cyc[i], e_data[i], e_last[i], e_err[i], hs_cyc[i]);
            end
        end
    endtask

    task automatic test_rresp_err();
        clear_cfg();
        for (int i = 0; i < 4; i++) push_beat(32'hC000_0100 + 32'(i), (i == 1) ? 2'b10 : 2'b00, i == 3, 0);
        build_expect(8'd3);
        run_burst(32'h0000_C000, 8'd3);
        n_checks++;
        if (timed_out || o_data.size() != 4) begin
            n_fail++;
            $display("FAIL rresp_count: pulses=%0d timeout=%b, want 4", o_data.size(), timed_out);
        end
        for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
            n_checks++;
            if (o_data[i] !== e_data[i] || o_last[i] !== e_last[i] || o_err[i] !== e_err[i]) begin
                n_fail++;
                $display("FAIL rresp_beat%0d: data=%h last=%b err=%b, want data=%h last=%b err=%b",
                         i, o_data[i], o_last[i], o_err[i], e_data[i], e_last[i], e_err[i]);
            end
        end
    endtask

    task automatic test_early_rlast();
        clear_cfg();
        push_beat(32'hE000_0001, 2'b00, 1'b0, 0);
        push_beat(32'hE000_0002, 2'b00, 1'b1, 0);
        build_expect(8'd3);
        run_burst(32'h0000_E000, 8'd3);
        n_checks++;
        if (timed_out || o_data.size() != 2) begin
            n_fail++;
            $display("FAIL early_count: pulses=%0d timeout=%b, want 2", o_data.size(), timed_out);
        end
        for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
            n_checks++;
            if (o_data[i] !== e_data[i] || o_last[i] !== e_last[i] || o_err[i] !== e_err[i]) begin
                n_fail++;
                $display("FAIL early_beat%0d: data=%h last=%b err=%b, want data=%h last=%b err=%b",
                         i, o_data[i], o_last[i], o_err[i], e_data[i], e_last[i], e_err[i]);
            end
        end
        n_checks++;
        if (axi.rready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_idle: rready=%b, want 0", axi.rready);
        end
    endtask

    task automatic test_missing_rlast();
        int rlast_cyc;
        clear_cfg();
        for (int i = 0; i < 6; i++) push_beat(32'hF000_0000 + 32'(i), 2'b00, i == 5, 0);
        cfg_next_req = 1'b1; cfg_next_addr = 32'h4000_0080; cfg_next_len = 8'd1;
        build_expect(8'd3);
        run_burst(32'h0000_F000, 8'd3);
        n_checks++;
        if (timed_out || o_data.size() != 4 || hs_cyc.size() != 6) begin
            n_fail++;
            $display("FAIL missing_count: pulses=%0d beats=%0d timeout=%b, want 4 6", o_data.size(), hs_cyc.size(), timed_out);
        end
        for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
            n_checks++;
            if (o_data[i] !== e_data[i] || o_last[i] !== e_last[i] || o_err[i] !== e_err[i]) begin
                n_fail++;
                $display("FAIL missing_beat%0d: data=%h last=%b err=%b, want data=%h last=%b err=%b",
                         i, o_data[i], o_last[i], o_err[i], e_data[i], e_last[i], e_err[i]);
            end
        end
        rlast_cyc = (hs_cyc.size() == 6) ? hs_cyc[5] : (1 << 30);
        n_checks++;
        if (second_ar_cyc < 0 || second_ar_cyc <= rlast_cyc) begin
            n_fail++;
            $display("FAIL missing_next_ar: arvalid_cyc=%0d, want later than rlast_cyc=%0d", second_ar_cyc, rlast_cyc);
        end
        // finish the queued request
        clear_cfg();
        push_beat(32'h5555_0001, 2'b00, 1'b0, 0);
        push_beat(32'h5555_0002, 2'b00, 1'b1, 0);
        build_expect(8'd1);
        run_burst(32'h4000_0080, 8'd1);
        n_checks++;
        if (timed_out || ar_addr_bad || o_data.size() != 2 || o_data[o_data.size()-1] !== 32'h5555_0002
            || o_err[o_data.size()-1] !== 1'b0) begin
            n_fail++;
            $display("FAIL missing_followup: pulses=%0d bad_addr=%b timeout=%b, want 2 pulses ending 55550002 err=0",
                     o_data.size(), ar_addr_bad, timed_out);
        end
    endtask

    task automatic test_abort();
        int want;
        clear_cfg();
        cfg_drop_after = 1;
        for (int i = 0; i < 4; i++) push_beat(32'hAB00_0000 + 32'(i), 2'b00, i == 3, 0);
        run_burst(32'h0000_AB00, 8'd3);
        want = 0;
        foreach (hs_cyc[i]) if (hs_cyc[i] < drop_cyc) want++;
        n_checks++;
        if (timed_out || hs_cyc.size() != 4 || o_data.size() != want) begin
            n_fail++;
            $display("FAIL abort_count: pulses=%0d beats=%0d timeout=%b, want pulses=%0d beats=4",
                     o_data.size(), hs_cyc.size(), timed_out, want);
        end
        foreach (o_last[i]) begin
            n_checks++;
            if (o_last[i] !== 1'b0 || o_data[i] !== b_data[i]) begin
                n_fail++;
                $display("FAIL abort_beat%0d: data=%h last=%b, want data=%h last=0", i, o_data[i], o_last[i], b_data[i]);
            end
        end
        n_checks++;
        if (axi.rready !== 1'b0 || axi.arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: rready=%b arvalid=%b, want 0 0", axi.rready, axi.arvalid);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clock);
        cache_r_valid_i = 1'b1; cache_r_addr_i = 32'h5000_0000; cache_r_len_i = 8'd3;
        for (int i = 0; i < 20 && !axi.arvalid; i++) @(negedge clock);
        n_checks++;
        if (axi.arvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ar: arvalid=%b, want 1 within 20 cycles", axi.arvalid);
        end
        axi.arready = 1'b1;
        @(negedge clock);
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'h1111_1111; axi.rresp = 2'b00; axi.rlast = 1'b0;
        @(negedge clock);
        axi.rdata = 32'h2222_2222;
        @(negedge clock);
        reset = 1'b0;
        axi.rvalid = 1'b0;
        #1;
        n_checks++;
        if ({cache_r_ready_o, cache_r_last_o, cache_r_err_o, axi.arvalid, axi.rready} !== 5'b0
            || cache_r_data_o !== 32'h0 || axi.araddr !== 32'h0 || axi.arlen !== 8'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: rdy=%b last=%b err=%b arv=%b rrdy=%b data=%h araddr=%h arlen=%h, want all 0",
                     cache_r_ready_o, cache_r_last_o, cache_r_err_o, axi.arvalid, axi.rready,
                     cache_r_data_o, axi.araddr, axi.arlen);
        end
        cache_r_valid_i = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        clear_cfg();
        push_beat(32'h6666_0001, 2'b00, 1'b0, 0);
        push_beat(32'h6666_0002, 2'b00, 1'b1, 0);
        build_expect(8'd1);
        run_burst(32'h6000_0040, 8'd1);
        n_checks++;
        if (timed_out || ar_addr_bad || first_ar_cyc != req_cyc || o_data.size() != 2) begin
            n_fail++;
            $display("FAIL midrst_fresh: bad_addr=%b first_ar=%0d pulses=%0d timeout=%b, want bad_addr=0 first_ar=%0d pulses=2",
                     ar_addr_bad, first_ar_cyc, o_data.size(), timed_out, req_cyc);
        end
        for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
            n_checks++;
            if (o_data[i] !== e_data[i] || o_last[i] !== e_last[i] || o_err[i] !== e_err[i]) begin
                n_fail++;
                $display("FAIL midrst_beat%0d: data=%h last=%b err=%b, want data=%h last=%b err=%b",
                         i, o_data[i], o_last[i], o_err[i], e_data[i], e_last[i], e_err[i]);
            end
        end
    endtask

    task automatic test_long_burst();
        clear_cfg();
        for (int i = 0; i < 256; i++) push_beat($urandom, 2'b00, i == 255, 0);
        build_expect(8'd255);
        run_burst(32'h7000_0000, 8'd255);
        n_checks++;
        if (timed_out || o_data.size() != 256) begin
            n_fail++;
            $display("FAIL long_count: pulses=%0d timeout=%b, want 256", o_data.size(), timed_out);
        end
        for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
            n_checks++;
            if (o_data[i] !== e_data[i] || o_last[i] !== e_last[i] || o_err[i] !== e_err[i]) begin
                n_fail++;
                $display("FAIL long_beat%0d: data=%h last=%b err=%b, want data=%h last=%b err=%b",
                         i, o_data[i], o_last[i], o_err[i], e_data[i], e_last[i], e_err[i]);
            end
        end
    endtask

    task automatic test_random();
        int          len, n, mode, e;
        logic [31:0] addr;
        for (int t = 0; t < 25; t++) begin
            clear_cfg();
            cfg_ar_delay = $urandom_range(0, 3);
            len  = $urandom_range(0, 7);
            mode = $urandom_range(0, 5);
            if (mode == 0 && len > 0) begin
                e = $urandom_range(0, len - 1); n = e + 1;
            end else if (mode == 1) begin
                n = len + 1 + $urandom_range(1, 3);
            end else begin
                n = len + 1;
            end
            for (int i = 0; i < n; i++)
                push_beat($urandom, ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                          i == n - 1, $urandom_range(0, 2));
            addr = $urandom & 32'hFFFF_FFFC;
            build_expect(8'(len));
            run_burst(addr, 8'(len));
            n_checks++;
            if (timed_out || ar_addr_bad || o_data.size() != e_data.size() || hs_cyc.size() != n) begin
                n_fail++;
                $display("FAIL rand%0d_count: pulses=%0d beats=%0d bad_addr=%b timeout=%b, want pulses=%0d beats=%0d",
                         t, o_data.size(), hs_cyc.size(), ar_addr_bad, timed_out, e_data.size(), n);
            end
            for (int i = 0; i < o_data.size() && i < e_data.size() && i < hs_cyc.size(); i++) begin
                n_checks++;
                if (o_data[i] !== e_data[i] || o_last[i] !== e_last[i] || o_err[i] !== e_err[i] || o_cyc[i] != hs_cyc[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: data=%h last=%b err=%b cyc=%0d, want data=%h last=%b err=%b cyc=%0d",
                             t, i, o_data[i], o_last[i], o_err[i], o_cyc[i], e_data[i], e_last[i], e_err[i], hs_cyc[i]);
                end
            end
        end
    endtask

    initial begin
        cache_r_valid_i = 1'b0; cache_r_addr_i = 32'h0; cache_r_len_i = 8'h0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0;
        axi.rresp = 2'b00; axi.rlast = 1'b0;
        test_reset();
        test_single();
        test_ar_delay();
        test_rvalid_gaps();
        test_rresp_err();
        test_early_rlast();
        test_missing_rlast();
        test_abort();
        test_mid_reset();
        test_long_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
